// File: rtl/roce_stack_addr_xlat_responder_if.sv
// roce_stack_addr_xlat_responder_if: rd/wr lookup channels, table config port and miss counter
interface roce_stack_addr_xlat_responder_if #(
   parameter int NUM_ENTRIES = 8,
   parameter int CFG_IDX_W = $clog2(NUM_ENTRIES)
);
   logic                 rd_req_addr_valid_i;
   logic                 rd_req_addr_ready_o;
   logic [63:0]          rd_req_addr_vaddr_i;
   logic                 rd_resp_addr_valid_o;
   logic                 rd_resp_addr_ready_i;
   logic [115:0]         rd_resp_addr_data_o;
   logic                 wr_req_addr_valid_i;
   logic                 wr_req_addr_ready_o;
   logic [63:0]          wr_req_addr_vaddr_i;
   logic                 wr_resp_addr_valid_o;
   logic                 wr_resp_addr_ready_i;
   logic [115:0]         wr_resp_addr_data_o;
   logic                 cfg_wr_en_i;
   logic [CFG_IDX_W-1:0] cfg_idx_i;
   logic                 cfg_valid_i;
   logic [63:0]          cfg_vbase_i;
   logic [63:0]          cfg_pbase_i;
   logic [47:0]          cfg_len_i;
   logic [31:0]          miss_cnt_o;
   modport master (
      output rd_req_addr_valid_i, rd_req_addr_vaddr_i, rd_resp_addr_ready_i,
      output wr_req_addr_valid_i, wr_req_addr_vaddr_i, wr_resp_addr_ready_i,
      output cfg_wr_en_i, cfg_idx_i, cfg_valid_i, cfg_vbase_i, cfg_pbase_i, cfg_len_i,
      input  rd_req_addr_ready_o, rd_resp_addr_valid_o, rd_resp_addr_data_o,
      input  wr_req_addr_ready_o, wr_resp_addr_valid_o, wr_resp_addr_data_o,
      input  miss_cnt_o
   );
   modport slave (
      input  rd_req_addr_valid_i, rd_req_addr_vaddr_i, rd_resp_addr_ready_i,
      input  wr_req_addr_valid_i, wr_req_addr_vaddr_i, wr_resp_addr_ready_i,
      input  cfg_wr_en_i, cfg_idx_i, cfg_valid_i, cfg_vbase_i, cfg_pbase_i, cfg_len_i,
      output rd_req_addr_ready_o, rd_resp_addr_valid_o, rd_resp_addr_data_o,
      output wr_req_addr_ready_o, wr_resp_addr_valid_o, wr_resp_addr_data_o,
      output miss_cnt_o
   );
endinterface

// File: rtl/roce_stack_addr_xlat_responder.sv
// roce_stack_addr_xlat_responder: shared round-robin vaddr->paddr lookup engine for rd/wr request handlers
module roce_stack_addr_xlat_responder #(
   parameter int NUM_ENTRIES = 8
) (
   input logic axis_aclk_i,
   input logic areset_i,
   roce_stack_addr_xlat_responder_if.slave bus
);
   localparam int CFG_IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [1:0] IDLE = 2'd0, LOOKUP = 2'd1, RESP = 2'd2;

   logic [1:0]             state;
   logic                   rr;
   logic                   ch;
   logic                   sel_wr;
   logic                   accept;
   logic                   resp_hs;
   logic                   cfg_ok;
   logic [63:0]            vaddr;
   logic [115:0]           resp;
   logic [31:0]            miss_cnt;
   logic [NUM_ENTRIES-1:0] tbl_valid;
   logic [63:0]            tbl_vbase [NUM_ENTRIES];
   logic [63:0]            tbl_pbase [NUM_ENTRIES];
   logic [47:0]            tbl_len   [NUM_ENTRIES];
   logic [63:0]            off       [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] hit_vec;
   logic                   lk_hit;
   logic [63:0]            lk_paddr;
   logic [47:0]            lk_remain;

   // rr=1 favours wr when both channels request
   assign sel_wr = bus.wr_req_addr_valid_i && (!bus.rd_req_addr_valid_i || rr);
   assign bus.rd_req_addr_ready_o = state == IDLE && bus.rd_req_addr_valid_i && !sel_wr;
   assign bus.wr_req_addr_ready_o = state == IDLE && sel_wr;
   assign accept = bus.rd_req_addr_ready_o || bus.wr_req_addr_ready_o;
   assign bus.rd_resp_addr_valid_o = state == RESP && !ch;
   assign bus.wr_resp_addr_valid_o = state == RESP && ch;
   assign resp_hs = (bus.rd_resp_addr_valid_o && bus.rd_resp_addr_ready_i) ||
                    (bus.wr_resp_addr_valid_o && bus.wr_resp_addr_ready_i);
   assign bus.rd_resp_addr_data_o = resp;
   assign bus.wr_resp_addr_data_o = resp;
   assign bus.miss_cnt_o = miss_cnt;
   assign cfg_ok = bus.cfg_wr_en_i && ({1'b0, bus.cfg_idx_i} < (CFG_IDX_W+1)'(NUM_ENTRIES));

   // once vaddr>=vbase the offset is exact, so offset<len equals the unwrapped end-bound test
   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
      assign off[g] = vaddr - tbl_vbase[g];
      assign hit_vec[g] = tbl_valid[g] && tbl_len[g] != '0 && vaddr >= tbl_vbase[g] &&
                          off[g] < {16'b0, tbl_len[g]};
   end

   always_comb begin
      lk_hit = 1'b0;
      lk_paddr = '0;
      lk_remain = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            lk_hit = 1'b1;
            lk_paddr = tbl_pbase[i] + off[i];
            lk_remain = tbl_len[i] - off[i][47:0];
         end
      end
   end

   always_ff @(posedge axis_aclk_i) begin
      if (cfg_ok) begin
         tbl_vbase[bus.cfg_idx_i] <= bus.cfg_vbase_i;
         tbl_pbase[bus.cfg_idx_i] <= bus.cfg_pbase_i;
         tbl_len[bus.cfg_idx_i] <= bus.cfg_len_i;
      end
   end

   always_ff @(posedge axis_aclk_i) begin
      if (areset_i) begin
         state <= IDLE;
         rr <= 1'b0;
         ch <= 1'b0;
         vaddr <= '0;
         resp <= '0;
         miss_cnt <= '0;
         tbl_valid <= '0;
      end else begin
         if (cfg_ok) tbl_valid[bus.cfg_idx_i] <= bus.cfg_valid_i;
         if (state == IDLE && accept) begin
            vaddr <= sel_wr ? bus.wr_req_addr_vaddr_i : bus.rd_req_addr_vaddr_i;
            ch <= sel_wr;
            rr <= !sel_wr;
            state <= LOOKUP;
         end
         if (state == LOOKUP) begin
            resp <= {3'b000, lk_hit, lk_remain, lk_paddr};
            state <= RESP;
         end
         if (resp_hs) begin
            state <= IDLE;
            if (!resp[112] && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_roce_stack_addr_xlat_responder.sv
// tb_roce_stack_addr_xlat_responder: random and directed lookups checked against a region-table model
module tb_roce_stack_addr_xlat_responder;
   localparam int N = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   roce_stack_addr_xlat_responder_if #(.NUM_ENTRIES(N)) bus ();
   roce_stack_addr_xlat_responder #(.NUM_ENTRIES(N)) dut (
      .axis_aclk_i(clk),
      .areset_i(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   bit          m_v   [N];
   logic [63:0] m_vb  [N];
   logic [63:0] m_pb  [N];
   logic [47:0] m_len [N];
   bit          rr_m;
   logic [31:0] miss_m;
   int          p_idx;
   logic [63:0] p_vb, p_pb;
   logic [47:0] p_len;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // first covering region in index order, bounds evaluated in 65-bit arithmetic
   function automatic logic [115:0] model(input logic [63:0] va);
      logic [64:0] lim;
      for (int i = 0; i < N; i++) begin
         lim = {1'b0, m_vb[i]} + {17'b0, m_len[i]};
         if (m_v[i] && m_len[i] != 0 && va >= m_vb[i] && {1'b0, va} < lim)
            return {3'b000, 1'b1, 48'(lim - {1'b0, va}), m_pb[i] + (va - m_vb[i])};
      end
      return '0;
   endfunction

   task automatic reset_model();
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      rr_m = 1'b0;
      miss_m = '0;
   endtask

   task automatic cfg_write(input int idx, input bit v, input logic [63:0] vb, input logic [63:0] pb,
                            input logic [47:0] len);
      @(negedge clk);
      bus.cfg_wr_en_i = 1'b1;
      bus.cfg_idx_i = 3'(idx);
      bus.cfg_valid_i = v;
      bus.cfg_vbase_i = vb;
      bus.cfg_pbase_i = pb;
      bus.cfg_len_i = len;
      @(posedge clk);
      #1 bus.cfg_wr_en_i = 1'b0;
      m_v[idx] = v;
      m_vb[idx] = vb;
      m_pb[idx] = pb;
      m_len[idx] = len;
   endtask

   task automatic lookup(input bit wr, input logic [63:0] va, input int hold, input bit late_cfg);
      logic [115:0] exp;
      logic rdy;
      int n;
      @(negedge clk);
      if (wr) begin
         bus.wr_req_addr_valid_i = 1'b1;
         bus.wr_req_addr_vaddr_i = va;
      end else begin
         bus.rd_req_addr_valid_i = 1'b1;
         bus.rd_req_addr_vaddr_i = va;
      end
      #1;
      n = 0;
      rdy = wr ? bus.wr_req_addr_ready_o : bus.rd_req_addr_ready_o;
      while (!rdy && n < 20) begin
         @(negedge clk);
         #1;
         n++;
         rdy = wr ? bus.wr_req_addr_ready_o : bus.rd_req_addr_ready_o;
      end
      check("req_ready", rdy, 1);
      if (!rdy) begin
         bus.rd_req_addr_valid_i = 1'b0;
         bus.wr_req_addr_valid_i = 1'b0;
         return;
      end
      exp = model(va);
      rr_m = !wr;
      @(posedge clk);
      #1;
      bus.rd_req_addr_valid_i = 1'b0;
      bus.wr_req_addr_valid_i = 1'b0;
      if (late_cfg) begin
         bus.cfg_wr_en_i = 1'b1;
         bus.cfg_idx_i = 3'(p_idx);
         bus.cfg_valid_i = 1'b1;
         bus.cfg_vbase_i = p_vb;
         bus.cfg_pbase_i = p_pb;
         bus.cfg_len_i = p_len;
      end
      @(negedge clk);
      check("lookup_no_valid", {bus.rd_resp_addr_valid_o, bus.wr_resp_addr_valid_o}, 0);
      @(posedge clk);
      #1;
      if (late_cfg) begin
         bus.cfg_wr_en_i = 1'b0;
         m_v[p_idx] = 1'b1;
         m_vb[p_idx] = p_vb;
         m_pb[p_idx] = p_pb;
         m_len[p_idx] = p_len;
      end
      @(negedge clk);
      check("resp_valid", {bus.rd_resp_addr_valid_o, bus.wr_resp_addr_valid_o}, wr ? 2'b01 : 2'b10);
      check("resp_data", wr ? bus.wr_resp_addr_data_o : bus.rd_resp_addr_data_o, exp);
      if (hold > 0) begin
         if (wr) bus.rd_req_addr_valid_i = 1'b1;
         else bus.wr_req_addr_valid_i = 1'b1;
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_data", wr ? bus.wr_resp_addr_data_o : bus.rd_resp_addr_data_o, exp);
         check("hold_valid", wr ? bus.wr_resp_addr_valid_o : bus.rd_resp_addr_valid_o, 1);
         check("hold_no_accept", {bus.rd_req_addr_ready_o, bus.wr_req_addr_ready_o}, 0);
      end
      bus.rd_req_addr_valid_i = 1'b0;
      bus.wr_req_addr_valid_i = 1'b0;
      if (wr) bus.wr_resp_addr_ready_i = 1'b1;
      else bus.rd_resp_addr_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.rd_resp_addr_ready_i = 1'b0;
      bus.wr_resp_addr_ready_i = 1'b0;
      if (!exp[112] && miss_m != 32'hFFFF_FFFF) miss_m++;
      @(negedge clk);
      check("miss_cnt", bus.miss_cnt_o, miss_m);
      check("resp_done", {bus.rd_resp_addr_valid_o, bus.wr_resp_addr_valid_o}, 0);
   endtask

   initial begin
      logic [115:0] exp;
      logic gw;
      int n;
      bus.rd_req_addr_valid_i = 1'b0;
      bus.rd_req_addr_vaddr_i = '0;
      bus.rd_resp_addr_ready_i = 1'b0;
      bus.wr_req_addr_valid_i = 1'b0;
      bus.wr_req_addr_vaddr_i = '0;
      bus.wr_resp_addr_ready_i = 1'b0;
      bus.cfg_wr_en_i = 1'b0;
      bus.cfg_idx_i = '0;
      bus.cfg_valid_i = 1'b0;
      bus.cfg_vbase_i = '0;
      bus.cfg_pbase_i = '0;
      bus.cfg_len_i = '0;
      reset_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {bus.rd_req_addr_ready_o, bus.wr_req_addr_ready_o}, 0);
      check("rst_valid", {bus.rd_resp_addr_valid_o, bus.wr_resp_addr_valid_o}, 0);
      check("rst_data", bus.rd_resp_addr_data_o, 0);
      check("rst_miss", bus.miss_cnt_o, 0);

      lookup(0, 64'h1000, 0, 0);
      cfg_write(0, 1, 64'h1000, 64'h8000_0000, 48'h2000);
      lookup(0, 64'h1800, 0, 0);
      lookup(0, 64'h3000, 0, 0);
      lookup(1, 64'h2FFF, 0, 0);
      lookup(1, 64'h0FFF, 0, 0);
      cfg_write(2, 1, 64'h3800, 64'hA000_0000, 48'h1000);
      cfg_write(5, 1, 64'h4000, 64'hB000_0000, 48'h1000);
      lookup(0, 64'h4000, 0, 0);
      lookup(0, 64'h1800, 10, 0);
      lookup(1, 64'h1800, 10, 0);

      p_idx = 7;
      p_vb = 64'h9000;
      p_pb = 64'hC000_0000;
      p_len = 48'h100;
      lookup(1, 64'h9010, 0, 1);
      lookup(1, 64'h9010, 0, 0);

      // both channels requesting continuously: grants must alternate
      @(negedge clk);
      bus.rd_req_addr_valid_i = 1'b1;
      bus.rd_req_addr_vaddr_i = 64'h1800;
      bus.wr_req_addr_valid_i = 1'b1;
      bus.wr_req_addr_vaddr_i = 64'h4000;
      bus.rd_resp_addr_ready_i = 1'b1;
      bus.wr_resp_addr_ready_i = 1'b1;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         #1;
         while (!(bus.rd_req_addr_ready_o || bus.wr_req_addr_ready_o) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
         end
         check("alt_grant", {bus.rd_req_addr_ready_o, bus.wr_req_addr_ready_o}, rr_m ? 2'b01 : 2'b10);
         gw = bus.wr_req_addr_ready_o;
         exp = model(gw ? 64'h4000 : 64'h1800);
         rr_m = !gw;
         @(posedge clk);
         @(negedge clk);
         check("alt_lookup", {bus.rd_resp_addr_valid_o, bus.wr_resp_addr_valid_o}, 0);
         @(negedge clk);
         check("alt_resp_ch", {bus.rd_resp_addr_valid_o, bus.wr_resp_addr_valid_o}, gw ? 2'b01 : 2'b10);
         check("alt_data", gw ? bus.wr_resp_addr_data_o : bus.rd_resp_addr_data_o, exp);
         if (!exp[112]) miss_m++;
      end
      @(posedge clk);
      #1;
      bus.rd_req_addr_valid_i = 1'b0;
      bus.wr_req_addr_valid_i = 1'b0;
      bus.rd_resp_addr_ready_i = 1'b0;
      bus.wr_resp_addr_ready_i = 1'b0;
      @(negedge clk);
      check("alt_miss", bus.miss_cnt_o, miss_m);

      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 2) == 0)
            cfg_write($urandom_range(0, N - 1), 1'($urandom_range(0, 3) != 0),
                      64'h10000 * $urandom_range(0, 3) + 64'($urandom_range(0, 'h800)),
                      {$urandom, $urandom}, 48'($urandom_range(0, 'h3000)));
         lookup(1'($urandom_range(0, 1)),
                64'h10000 * $urandom_range(0, 3) + 64'($urandom_range(0, 'h3100)),
                $urandom_range(0, 3), 0);
      end

      cfg_write(3, 1, 64'hFFFF_FFFF_FFFF_F000, 64'h2000_0000, 48'h1000);
      lookup(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);

      // reset while the lookup is in flight
      @(negedge clk);
      bus.rd_req_addr_valid_i = 1'b1;
      bus.rd_req_addr_vaddr_i = 64'hFFFF_FFFF_FFFF_F800;
      #1 check("rst_mid_ready", bus.rd_req_addr_ready_o, 1);
      @(posedge clk);
      #1;
      bus.rd_req_addr_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      reset_model();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_mid_valid", {bus.rd_resp_addr_valid_o, bus.wr_resp_addr_valid_o}, 0);
         check("rst_mid_data", bus.rd_resp_addr_data_o, 0);
         check("rst_mid_miss", bus.miss_cnt_o, 0);
      end
      lookup(0, 64'hFFFF_FFFF_FFFF_F800, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
